// File: rtl/count_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : count_sequencer
// Description : Synchronous up/down counter with a built-in run sequencer.
//               A run latches start/terminal value, direction, reload mode
//               and prescale, then advances Q once every prescale+1 clocks.
//               On the terminal value it pulses tc and either reloads
//               (periodic) or parks in DONE (one-shot).
// Revision    : 1.0 - initial release
// ============================================================================
module count_sequencer #(
    parameter int WIDTH = 4,
    parameter int PSW   = 4
) (
    input  logic             clk,
    input  logic             reset,        // active-low, asynchronous
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             up_dn,
    input  logic             auto_reload,
    input  logic [PSW-1:0]   prescale,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    localparam logic [1:0] c_IDLE = 2'b00;
    localparam logic [1:0] c_RUN  = 2'b01;
    localparam logic [1:0] c_HOLD = 2'b10;
    localparam logic [1:0] c_DONE = 2'b11;

    logic [1:0]       r_state, w_state;
    logic [WIDTH-1:0] r_q, w_q;
    logic             r_tc, w_tc;
    logic [PSW-1:0]   r_pcnt, w_pcnt;

    // Shadow copy of the run configuration, captured when a run starts
    logic [WIDTH-1:0] r_sh_load, w_sh_load;
    logic [WIDTH-1:0] r_sh_limit, w_sh_limit;
    logic             r_sh_up, w_sh_up;
    logic             r_sh_auto, w_sh_auto;
    logic [PSW-1:0]   r_sh_psc, w_sh_psc;

    logic w_tick;
    logic w_at_limit;

    assign w_tick     = (r_pcnt == r_sh_psc);
    assign w_at_limit = (r_q == r_sh_limit);

    // Next-state, count and configuration-capture logic; stop > pause > start
    always_comb begin
        w_state    = r_state;
        w_q        = r_q;
        w_tc       = 1'b0;
        w_pcnt     = r_pcnt;
        w_sh_load  = r_sh_load;
        w_sh_limit = r_sh_limit;
        w_sh_up    = r_sh_up;
        w_sh_auto  = r_sh_auto;
        w_sh_psc   = r_sh_psc;

        case (r_state)
            c_IDLE, c_DONE: begin
                // pause has no meaning here; only stop and start act
                if (stop) begin
                    w_state = c_IDLE;
                end else if (start) begin
                    w_state    = c_RUN;
                    w_q        = load_val;
                    w_pcnt     = '0;
                    w_sh_load  = load_val;
                    w_sh_limit = limit;
                    w_sh_up    = up_dn;
                    w_sh_auto  = auto_reload;
                    w_sh_psc   = prescale;
                end
            end
            c_RUN: begin
                if (stop) begin
                    w_state = c_IDLE;
                end else if (pause) begin
                    w_state = c_HOLD;
                end else if (w_tick) begin
                    w_pcnt = '0;
                    if (w_at_limit) begin
                        w_tc = 1'b1;
                        if (r_sh_auto) begin
                            w_q = r_sh_load;
                        end else begin
                            w_state = c_DONE;
                        end
                    end else if (r_sh_up) begin
                        w_q = r_q + WIDTH'(1);
                    end else begin
                        w_q = r_q - WIDTH'(1);
                    end
                end else begin
                    w_pcnt = r_pcnt + PSW'(1);
                end
            end
            c_HOLD: begin
                // Resume keeps the frozen prescale phase and count
                if (stop) begin
                    w_state = c_IDLE;
                end else if (start) begin
                    w_state = c_RUN;
                end
            end
            default: begin
                w_state = c_IDLE;
            end
        endcase
    end

    // State, count, pulse and shadow registers with asynchronous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_IDLE;
            r_q        <= '0;
            r_tc       <= 1'b0;
            r_pcnt     <= '0;
            r_sh_load  <= '0;
            r_sh_limit <= '0;
            r_sh_up    <= 1'b0;
            r_sh_auto  <= 1'b0;
            r_sh_psc   <= '0;
        end else begin
            r_state    <= w_state;
            r_q        <= w_q;
            r_tc       <= w_tc;
            r_pcnt     <= w_pcnt;
            r_sh_load  <= w_sh_load;
            r_sh_limit <= w_sh_limit;
            r_sh_up    <= w_sh_up;
            r_sh_auto  <= w_sh_auto;
            r_sh_psc   <= w_sh_psc;
        end
    end

    assign Q     = r_q;
    assign tc    = r_tc;
    assign state = r_state;
    assign busy  = (r_state == c_RUN) || (r_state == c_HOLD);
    assign done  = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_count_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_sequencer
// Description : Scoreboard bench for count_sequencer. Each queued entry holds
//               the commands/config driven before one clock edge and the
//               Q/tc/state expected after that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_sequencer;

    localparam logic [1:0] IDL = 2'b00;
    localparam logic [1:0] RUN = 2'b01;
    localparam logic [1:0] HLD = 2'b10;
    localparam logic [1:0] DON = 2'b11;

    // command encodings {stop, pause, start}
    localparam logic [2:0] NONE = 3'b000;
    localparam logic [2:0] STA  = 3'b001;
    localparam logic [2:0] PAU  = 3'b010;
    localparam logic [2:0] STO  = 3'b100;

    logic       clk;
    logic       reset;
    logic       start, stop, pause;
    logic [3:0] load_val, limit;
    logic       up_dn, auto_reload;
    logic [3:0] prescale;
    logic [3:0] Q;
    logic       tc, busy, done;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] cmd;
        logic [3:0] ld;
        logic [3:0] lim;
        logic       up;
        logic       ar;
        logic [3:0] ps;
        logic [3:0] q;
        logic       t;
        logic [1:0] st;
    } entry_t;

    entry_t sb[$];

    // configuration snapshotted into each pushed entry
    logic [3:0] cfg_ld, cfg_lim, cfg_ps;
    logic       cfg_up, cfg_ar;

    count_sequencer #(.WIDTH(4), .PSW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .load_val   (load_val),
        .limit      (limit),
        .up_dn      (up_dn),
        .auto_reload(auto_reload),
        .prescale   (prescale),
        .Q          (Q),
        .tc         (tc),
        .busy       (busy),
        .done       (done),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push(input logic [2:0] cmd, input logic [3:0] q,
                                 input logic t, input logic [1:0] st);
        entry_t e;
        e.cmd = cmd;  e.ld = cfg_ld; e.lim = cfg_lim; e.up = cfg_up;
        e.ar  = cfg_ar; e.ps = cfg_ps; e.q = q; e.t = t; e.st = st;
        sb.push_back(e);
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        {stop, pause, start} = NONE;
        load_val = 4'd0; limit = 4'd0; up_dn = 1'b0; auto_reload = 1'b0; prescale = 4'd0;
        #1;
        total++;
        if ({Q, tc, state, busy, done} !== {4'd0, 1'b0, IDL, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_t0: got Q=%0d tc=%0b state=%0d busy=%0b done=%0b, want 0/0/0/0/0",
                     Q, tc, state, busy, done);
        end
        // start asserted while in reset must have no effect
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({Q, tc, state} !== {4'd0, 1'b0, IDL}) begin
            bad++;
            $display("FAIL reset_held: got Q=%0d tc=%0b state=%0d, want Q=0 tc=0 state=0", Q, tc, state);
        end
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset_midrun();
        entry_t e;
        int n = 0;
        cfg_ld = 4'd5; cfg_lim = 4'd9; cfg_up = 1'b1; cfg_ar = 1'b0; cfg_ps = 4'd15;
        push(STA,  4'd5, 1'b0, RUN);
        push(NONE, 4'd5, 1'b0, RUN);
        push(NONE, 4'd5, 1'b0, RUN);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            {stop, pause, start} = e.cmd;
            load_val = e.ld; limit = e.lim; up_dn = e.up; auto_reload = e.ar; prescale = e.ps;
            @(posedge clk);
            #1;
            total++;
            if ({Q, tc, state, busy, done} !== {e.q, e.t, e.st, (e.st == RUN || e.st == HLD), (e.st == DON)}) begin
                bad++;
                $display("FAIL arst_run[%0d]: got Q=%0d tc=%0b state=%0d busy=%0b done=%0b, want Q=%0d tc=%0b state=%0d",
                         n, Q, tc, state, busy, done, e.q, e.t, e.st);
            end
            n++;
        end
        {stop, pause, start} = NONE;
        #3;
        reset = 1'b0;
        #1;
        total++;
        if ({Q, tc, state} !== {4'd0, 1'b0, IDL}) begin
            bad++;
            $display("FAIL arst_immediate: got Q=%0d tc=%0b state=%0d, want Q=0 tc=0 state=0", Q, tc, state);
        end
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({Q, tc, state} !== {4'd0, 1'b0, IDL}) begin
            bad++;
            $display("FAIL arst_after: got Q=%0d tc=%0b state=%0d, want Q=0 tc=0 state=0", Q, tc, state);
        end
    endtask

    task automatic test_oneshot_up();
        entry_t e;
        int n = 0;
        cfg_ld = 4'd2; cfg_lim = 4'd5; cfg_up = 1'b1; cfg_ar = 1'b0; cfg_ps = 4'd0;
        push(STA,  4'd2, 1'b0, RUN);
        push(NONE, 4'd3, 1'b0, RUN);
        push(NONE, 4'd4, 1'b0, RUN);
        push(NONE, 4'd5, 1'b0, RUN);
        push(NONE, 4'd5, 1'b1, DON);
        push(NONE, 4'd5, 1'b0, DON);
        push(PAU,  4'd5, 1'b0, DON);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            {stop, pause, start} = e.cmd;
            load_val = e.ld; limit = e.lim; up_dn = e.up; auto_reload = e.ar; prescale = e.ps;
            @(posedge clk);
            #1;
            total++;
            if ({Q, tc, state, busy, done} !== {e.q, e.t, e.st, (e.st == RUN || e.st == HLD), (e.st == DON)}) begin
                bad++;
                $display("FAIL oneshot[%0d]: got Q=%0d tc=%0b state=%0d busy=%0b done=%0b, want Q=%0d tc=%0b state=%0d",
                         n, Q, tc, state, busy, done, e.q, e.t, e.st);
            end
            n++;
        end
        {stop, pause, start} = NONE;
    endtask

    task automatic test_periodic_down();
        entry_t e;
        int n = 0;
        cfg_ld = 4'd1; cfg_lim = 4'd14; cfg_up = 1'b0; cfg_ar = 1'b1; cfg_ps = 4'd2;
        push(STA, 4'd1, 1'b0, RUN);
        for (int p = 0; p < 2; p++) begin
            repeat (2) push(NONE, 4'd1,  1'b0, RUN);
            repeat (3) push(NONE, 4'd0,  1'b0, RUN);
            repeat (3) push(NONE, 4'd15, 1'b0, RUN);
            repeat (3) push(NONE, 4'd14, 1'b0, RUN);
            push(NONE, 4'd1, 1'b1, RUN);
        end
        push(STO,  4'd1, 1'b0, IDL);
        push(NONE, 4'd1, 1'b0, IDL);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            {stop, pause, start} = e.cmd;
            load_val = e.ld; limit = e.lim; up_dn = e.up; auto_reload = e.ar; prescale = e.ps;
            @(posedge clk);
            #1;
            total++;
            if ({Q, tc, state, busy, done} !== {e.q, e.t, e.st, (e.st == RUN || e.st == HLD), (e.st == DON)}) begin
                bad++;
                $display("FAIL periodic[%0d]: got Q=%0d tc=%0b state=%0d busy=%0b done=%0b, want Q=%0d tc=%0b state=%0d",
                         n, Q, tc, state, busy, done, e.q, e.t, e.st);
            end
            n++;
        end
        {stop, pause, start} = NONE;
    endtask

    task automatic test_pause_resume();
        entry_t e;
        int n = 0;
        cfg_ld = 4'd2; cfg_lim = 4'd5; cfg_up = 1'b1; cfg_ar = 1'b0; cfg_ps = 4'd2;
        push(STA,  4'd2, 1'b0, RUN);
        push(NONE, 4'd2, 1'b0, RUN);
        push(NONE, 4'd2, 1'b0, RUN);
        push(NONE, 4'd3, 1'b0, RUN);
        push(NONE, 4'd3, 1'b0, RUN);       // prescale phase now 1 of 0..2
        push(PAU,  4'd3, 1'b0, HLD);
        repeat (4) push(NONE, 4'd3, 1'b0, HLD);
        repeat (5) push(PAU,  4'd3, 1'b0, HLD);
        push(STA,  4'd3, 1'b0, RUN);       // resume, phase still 1
        push(NONE, 4'd3, 1'b0, RUN);
        push(NONE, 4'd4, 1'b0, RUN);
        push(NONE, 4'd4, 1'b0, RUN);
        push(NONE, 4'd4, 1'b0, RUN);
        push(NONE, 4'd5, 1'b0, RUN);
        push(NONE, 4'd5, 1'b0, RUN);
        push(NONE, 4'd5, 1'b0, RUN);
        push(NONE, 4'd5, 1'b1, DON);
        push(NONE, 4'd5, 1'b0, DON);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            {stop, pause, start} = e.cmd;
            load_val = e.ld; limit = e.lim; up_dn = e.up; auto_reload = e.ar; prescale = e.ps;
            @(posedge clk);
            #1;
            total++;
            if ({Q, tc, state, busy, done} !== {e.q, e.t, e.st, (e.st == RUN || e.st == HLD), (e.st == DON)}) begin
                bad++;
                $display("FAIL pause[%0d]: got Q=%0d tc=%0b state=%0d busy=%0b done=%0b, want Q=%0d tc=%0b state=%0d",
                         n, Q, tc, state, busy, done, e.q, e.t, e.st);
            end
            n++;
        end
        {stop, pause, start} = NONE;
    endtask

    task automatic test_priority();
        entry_t e;
        int n = 0;
        cfg_ld = 4'd9; cfg_lim = 4'd12; cfg_up = 1'b1; cfg_ar = 1'b0; cfg_ps = 4'd0;
        push(STA,         4'd9, 1'b0, RUN);   // fresh run from DONE
        push(STO|PAU|STA, 4'd9, 1'b0, IDL);   // stop wins, no count
        push(PAU,         4'd9, 1'b0, IDL);   // pause ignored in IDLE
        cfg_ld = 4'd4;
        push(PAU|STA,     4'd4, 1'b0, RUN);   // start wins over pause in IDLE
        push(NONE,        4'd5, 1'b0, RUN);
        push(PAU|STA,     4'd5, 1'b0, HLD);   // pause beats start in RUN
        push(STO|STA,     4'd5, 1'b0, IDL);   // stop beats start in HOLD
        while (sb.size() > 0) begin
            e = sb.pop_front();
            {stop, pause, start} = e.cmd;
            load_val = e.ld; limit = e.lim; up_dn = e.up; auto_reload = e.ar; prescale = e.ps;
            @(posedge clk);
            #1;
            total++;
            if ({Q, tc, state, busy, done} !== {e.q, e.t, e.st, (e.st == RUN || e.st == HLD), (e.st == DON)}) begin
                bad++;
                $display("FAIL priority[%0d]: got Q=%0d tc=%0b state=%0d busy=%0b done=%0b, want Q=%0d tc=%0b state=%0d",
                         n, Q, tc, state, busy, done, e.q, e.t, e.st);
            end
            n++;
        end
        {stop, pause, start} = NONE;
    endtask

    task automatic test_collisions();
        entry_t e;
        int n = 0;
        cfg_ld = 4'd3; cfg_lim = 4'd5; cfg_up = 1'b1; cfg_ar = 1'b0; cfg_ps = 4'd0;
        // stop on the terminal tick
        push(STA,  4'd3, 1'b0, RUN);
        push(NONE, 4'd4, 1'b0, RUN);
        push(NONE, 4'd5, 1'b0, RUN);
        push(STO,  4'd5, 1'b0, IDL);
        push(NONE, 4'd5, 1'b0, IDL);
        // pause on the terminal tick, resume makes the next tick terminal
        push(STA,  4'd3, 1'b0, RUN);
        push(NONE, 4'd4, 1'b0, RUN);
        push(NONE, 4'd5, 1'b0, RUN);
        push(PAU,  4'd5, 1'b0, HLD);
        push(STA,  4'd5, 1'b0, RUN);
        push(NONE, 4'd5, 1'b1, DON);
        // load equals limit: first tick terminal with no count change
        cfg_ld = 4'd7; cfg_lim = 4'd7;
        push(STA,  4'd7, 1'b0, RUN);
        push(NONE, 4'd7, 1'b1, DON);
        // config inputs change after latching; sequence follows latched values
        cfg_ld = 4'd13; cfg_lim = 4'd1; cfg_up = 1'b1;
        push(STA,  4'd13, 1'b0, RUN);
        cfg_ld = 4'd0; cfg_lim = 4'd14; cfg_up = 1'b0; cfg_ar = 1'b1; cfg_ps = 4'd3;
        push(NONE, 4'd14, 1'b0, RUN);
        push(STA,  4'd15, 1'b0, RUN);        // start ignored while running
        push(NONE, 4'd0,  1'b0, RUN);
        push(NONE, 4'd1,  1'b0, RUN);
        push(NONE, 4'd1,  1'b1, DON);
        push(NONE, 4'd1,  1'b0, DON);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            {stop, pause, start} = e.cmd;
            load_val = e.ld; limit = e.lim; up_dn = e.up; auto_reload = e.ar; prescale = e.ps;
            @(posedge clk);
            #1;
            total++;
            if ({Q, tc, state, busy, done} !== {e.q, e.t, e.st, (e.st == RUN || e.st == HLD), (e.st == DON)}) begin
                bad++;
                $display("FAIL collide[%0d]: got Q=%0d tc=%0b state=%0d busy=%0b done=%0b, want Q=%0d tc=%0b state=%0d",
                         n, Q, tc, state, busy, done, e.q, e.t, e.st);
            end
            n++;
        end
        {stop, pause, start} = NONE;
    endtask

    initial begin
        test_reset();
        test_async_reset_midrun();
        test_oneshot_up();
        test_periodic_down();
        test_pause_resume();
        test_priority();
        test_collisions();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
- Controller for the ripple-style counters in the counter labs, implemented as a synchronous counter with a built-in sequencer.
- Latches a configuration (start value, terminal value, direction, reload mode, prescale) when a run starts, then advances the count under a small state machine.
- Flags the terminal count and either stops or reloads.
- Sits between a top-level control FSM/testbench and any logic that consumes Q/tc.

Parameters:
WIDTH, 4, count and load/limit width
PSW, 4, prescale field width

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  begin run (from IDLE/DONE) or resume (from HOLD)
stop  input  1  abort to IDLE
pause  input  1  freeze a running count
load_val  input  WIDTH  start/reload value, latched on start from IDLE/DONE
limit  input  WIDTH  terminal value, latched on start from IDLE/DONE
up_dn  input  1  1 = count up, 0 = count down; latched on start
auto_reload  input  1  1 = periodic, 0 = one-shot; latched on start
prescale  input  PSW  advance every prescale+1 clocks; latched on start
Q  output  WIDTH  current count
tc  output  1  one-cycle terminal-count pulse
busy  output  1  high in RUN or HOLD
done  output  1  high in DONE
state  output  2  IDLE=00, RUN=01, HOLD=10, DONE=11

Behaviour:
- Reset (reset=0, asynchronous, independent of clk):
  - state=IDLE; Q=0; tc=0; prescale counter=0; all shadow config registers=0.
  - Takes effect immediately, including mid-run.
- Outputs:
  - busy and done decode state; they are not separately registered.
  - Q, tc and state are registered.
- Command priority, evaluated each clk edge: stop > pause > start.
- IDLE:
  - start → RUN. Same edge: Q<=load_val; latch limit/up_dn/auto_reload/prescale/load_val into shadows; prescale counter<=0.
  - pause is ignored.
- RUN:
  - A tick occurs on the edge where the prescale counter equals the shadow prescale. That edge also clears the prescale counter; otherwise the counter increments.
  - Tick with Q==shadow limit:
    - tc<=1 for exactly one cycle.
    - auto_reload=1: Q<=shadow load_val, stay RUN.
    - auto_reload=0: Q holds, go DONE.
  - Tick with Q!=limit: Q<=Q±1 modulo 2^WIDTH. Wrap-around is legal, e.g. up 1111→0000, down 0000→1111.
  - pause → HOLD; the prescale counter and Q freeze.
  - stop → IDLE; Q holds its last value; tc<=0.
  - start while in RUN is ignored. Inputs other than the commands are ignored after latching.
- HOLD:
  - start → RUN, resuming with the prescale counter and Q as frozen; no reload, no re-latch.
  - stop → IDLE.
  - pause is ignored.
- DONE:
  - Q holds the terminal value.
  - start → RUN with a fresh load/latch, same as from IDLE.
  - stop → IDLE.
- Latency:
  - Start at edge k: Q=load_val after edge k.
  - First tick at edge k+prescale+1.
  - Prescale=0: Q changes every clock.
- Boundary cases:
  - load_val==limit: first tick is terminal; tc fires without any count change.
  - Terminal tick and stop on the same edge: stop wins, no tc, go IDLE.
  - Terminal tick and pause on the same edge: pause wins, no tc; after resume, the next tick is terminal.
  - tc is never asserted outside the cycle after a terminal tick.
  - tc is 0 in IDLE and HOLD.

Test Plan:
1. Async reset mid-run: RUN with Q=0101; drive reset=0 between clock edges → Q=0000, state=00, tc=0 immediately, without waiting for clk.
2. One-shot up count: load_val=2, limit=5, up_dn=1, auto_reload=0, prescale=0, pulse start.
   - Q sequence 2,3,4,5 on successive edges.
   - tc pulses once on the edge after Q=5 is sampled.
   - state=11, done=1, Q stays 5.
3. Periodic down count with prescale and wrap: load_val=1, limit=14, up_dn=0, auto_reload=1, prescale=2.
   - Q goes 1,0,15,14, changing every 3 clocks.
   - tc pulse, Q reloads to 1, state stays 01.
   - Second period is identical.
4. Pause/resume: during scenario 2, assert pause when Q=3 mid-prescale.
   - state=10, Q frozen at 3 for 10 cycles.
   - start → counting resumes with remaining prescale count preserved, ends at 5 with a single tc.
5. Priority on same edge: stop+pause+start together in RUN → IDLE. In IDLE, pause+start → RUN with load.
6. Terminal-tick collision and mid-run config changes:
   - stop coincident with the terminal tick → IDLE, tc never asserted.
   - Changing limit or up_dn inputs mid-run has no effect on the running sequence.
